// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: ALU control codes and sequencer state encoding shared by the accumulator datapath.
package acc_seq_pkg;
  localparam logic [2:0] ALU_PASSB = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_RSUB  = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_AND   = 3'd5;
  localparam logic [2:0] ALU_SHL   = 3'd6;
  localparam logic [2:0] ALU_SHR   = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_OPRD, S_EXEC, S_WB, S_RESP} state_e;
endpackage

// File: rtl/acc_regfile.sv
// acc_regfile: NREGS x 16 register file, async read, load + write-back ports with load priority.
module acc_regfile #(
  parameter int NREGS = 4,
  localparam int IDXW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_we,
  input  logic [IDXW-1:0] ld_idx,
  input  logic [15:0]     ld_data,
  input  logic            wb_we,
  input  logic [IDXW-1:0] wb_idx,
  input  logic [15:0]     wb_data,
  input  logic [IDXW-1:0] rd_idx,
  output logic [15:0]     rd_data,
  output logic            collide
);
  logic [15:0] r_q [NREGS];
  logic        collide_q;
  assign rd_data = r_q[rd_idx];
  assign collide = collide_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
      collide_q <= 1'b0;
    end else begin
      if (wb_we) r_q[wb_idx] <= wb_data;
      // the load is written last so it overrides a same-register write-back
      if (ld_we) r_q[ld_idx] <= ld_data;
      collide_q <= wb_we && ld_we && (wb_idx == ld_idx);
    end
  end
endmodule

// File: rtl/acc_alu_sequencer.sv
// acc_alu_sequencer: five-state controller sequencing an external 16-bit ALU over ACC and a register file.
module acc_alu_sequencer
  import acc_seq_pkg::*;
#(
  parameter int NREGS = 4,
  localparam int IDXW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [IDXW-1:0] cmd_reg,
  input  logic            cmd_wb_acc,
  input  logic            ld_valid,
  input  logic [IDXW-1:0] ld_idx,
  input  logic [15:0]     ld_data,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [15:0]     alu_out,
  input  logic            alu_zero,
  input  logic            alu_ovf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_data,
  output logic            rsp_zero,
  output logic            rsp_ovf,
  output logic [15:0]     acc_q,
  output logic            busy,
  output logic            ld_collide
);
  state_e          state_q, state_d;
  logic [2:0]      op_q, alu_ctrl_q;
  logic [IDXW-1:0] reg_q;
  logic            wb_acc_q, rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_ovf_q;
  logic [15:0]     alu_a_q, alu_b_q, rsp_data_q, rd_data;
  assign cmd_ready = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  acc_regfile #(.NREGS(NREGS)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ld_we(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
    .wb_we(state_q == S_WB && !wb_acc_q), .wb_idx(reg_q), .wb_data(rsp_data_q),
    .rd_idx(reg_q), .rd_data(rd_data), .collide(ld_collide)
  );
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = cmd_valid ? S_OPRD : S_IDLE;
      S_OPRD: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_RESP;
      S_RESP: begin
        // first RESP cycle raises valid; the handshake then returns to IDLE
        rsp_valid_d = !(rsp_valid_q && rsp_ready);
        state_d     = rsp_valid_d ? S_RESP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      reg_q       <= '0;
      wb_acc_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (state_q == S_IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        reg_q    <= cmd_reg;
        wb_acc_q <= cmd_wb_acc;
      end
      if (state_q == S_OPRD) begin
        alu_a_q    <= acc_q;
        alu_b_q    <= rd_data;
        alu_ctrl_q <= op_q;
      end
      if (state_q == S_EXEC) begin
        rsp_data_q <= alu_out;
        rsp_zero_q <= alu_zero;
        rsp_ovf_q  <= alu_ovf;
      end
      if (state_q == S_WB && wb_acc_q) acc_q <= rsp_data_q;
    end
  end
endmodule

// File: tb/tb_acc_alu_sequencer.sv
// tb_acc_alu_sequencer: scoreboard bench with an arithmetic reference model and a behavioural external ALU.
module tb_acc_alu_sequencer;
  import acc_seq_pkg::*;
  localparam int NR = 4;
  localparam int IW = 2;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_wb_acc = 0, ld_valid = 0;
  logic [2:0] cmd_op = 0, alu_ctrl;
  logic [IW-1:0] cmd_reg = 0, ld_idx = 0;
  logic [15:0] ld_data = 0, alu_a, alu_b, alu_out, rsp_data, acc_q;
  logic alu_zero, alu_ovf, rsp_valid, rsp_ready = 1, rsp_zero, rsp_ovf, busy, ld_collide;

  acc_alu_sequencer #(.NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_wb_acc(cmd_wb_acc),
    .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .acc_q(acc_q), .busy(busy),
    .ld_collide(ld_collide)
  );

  always #5 clk = ~clk;

  // returns {ovf, zero, result}; overflow is signed-range overflow of the add/subtract
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, s;
    logic [15:0] r;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = 0;
    v = 1'b0;
    case (op)
      ALU_PASSB: r = b;
      ALU_ADD:   begin s = sa + sb; r = 16'(s); v = s > 32767 || s < -32768; end
      ALU_SUB:   begin s = sa - sb; r = 16'(s); v = s > 32767 || s < -32768; end
      ALU_RSUB:  begin s = sb - sa; r = 16'(s); v = s > 32767 || s < -32768; end
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_SHL:   r = (b >= 16) ? 16'h0 : 16'(int'(a) << b);
      default:   r = (b >= 16) ? 16'h0 : a >> b;
    endcase
    return {v, r == 16'h0, r};
  endfunction

  logic [17:0] alu_res;
  always_comb begin
    alu_res  = alu_f(alu_ctrl, alu_a, alu_b);
    alu_out  = alu_res[15:0];
    alu_zero = alu_res[16];
    alu_ovf  = alu_res[17];
  end

  typedef struct {logic [15:0] d; logic z; logic v; logic [15:0] acc;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [15:0] acc_m;
  logic [15:0] r_m [NR];
  int tests = 0, fails = 0, n_rsp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got data %0h with no command outstanding", rsp_data);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.d));
        chk("rsp_zero", 32'(rsp_zero), 32'(mon_e.z));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.v));
        chk("acc_q", 32'(acc_q), 32'(mon_e.acc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] idx, input logic [15:0] d);
    ld_valid = 1; ld_idx = idx; ld_data = d;
    tick();
    ld_valid = 0;
    r_m[idx] = d;
  endtask

  task automatic issue(input logic [2:0] op, input logic [IW-1:0] r, input logic wb);
    logic [17:0] f;
    exp_t e;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    f = alu_f(op, acc_m, r_m[r]);
    if (wb) acc_m = f[15:0];
    else r_m[r] = f[15:0];
    e = '{f[15:0], f[16], f[17], acc_m};
    q.push_back(e);
    cmd_valid = 1; cmd_op = op; cmd_reg = r; cmd_wb_acc = wb;
    tick();
    cmd_valid = 0;
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 200 && q.size() > 0; i++) begin
      rsp_ready = rnd ? 1'($urandom) : 1'b1;
      tick();
    end
    rsp_ready = 1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
    end
  endtask

  task automatic model_reset();
    acc_m = 0;
    for (int i = 0; i < NR; i++) r_m[i] = 0;
    q.delete();
  endtask

  initial begin
    int base;
    model_reset();
    #12;
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_alu_a", 32'(alu_a), 0);
    chk("reset_alu_b", 32'(alu_b), 0);
    chk("reset_alu_ctrl", 32'(alu_ctrl), 0);
    chk("reset_acc", 32'(acc_q), 0);
    chk("reset_collide", 32'(ld_collide), 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // basic ADD with latency checks
    load(1, 16'h0005);
    issue(ALU_ADD, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("lat_rsp_valid_T%0d", k), 32'(rsp_valid), 32'(k == 4));
      chk($sformatf("lat_cmd_ready_T%0d", k), 32'(cmd_ready), 32'(k == 5));
    end
    drain(0);

    // SUB to zero, write back to R2, read back via PASSB
    load(2, 16'h0005);
    issue(ALU_SUB, 2, 0);
    drain(0);
    issue(ALU_PASSB, 2, 1);
    drain(0);

    // signed overflow, then shift by 16
    load(0, 16'h4000);
    issue(ALU_PASSB, 0, 1);
    drain(0);
    issue(ALU_ADD, 0, 1);
    drain(0);
    load(1, 16'h0010);
    issue(ALU_SHL, 1, 1);
    drain(0);

    // backpressure: response holds, new commands ignored, exactly one transfer
    load(3, 16'h1234);
    rsp_ready = 0;
    issue(ALU_OR, 3, 1);
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    base = n_rsp;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1; cmd_op = 3'($urandom); cmd_reg = 2'($urandom); cmd_wb_acc = 1'($urandom);
      chk("hold_rsp_valid", 32'(rsp_valid), 1);
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
      if (q.size() > 0) chk("hold_rsp_data", 32'(rsp_data), 32'(q[0].d));
      tick();
    end
    cmd_valid = 0;
    tick();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("hold_one_transfer", 32'(n_rsp - base), 1);
    chk("hold_released_valid", 32'(rsp_valid), 0);
    chk("hold_released_ready", 32'(cmd_ready), 1);
    tick();
    tick();
    chk("hold_no_extra_busy", 32'(busy), 0);
    rsp_ready = 1;

    // write-back to R3 colliding with a load to R3
    issue(ALU_ADD, 3, 0);
    tick();
    tick();
    ld_valid = 1; ld_idx = 3; ld_data = 16'hBEEF;
    tick();
    ld_valid = 0;
    r_m[3] = 16'hBEEF;
    chk("collide_pulse", 32'(ld_collide), 1);
    tick();
    chk("collide_one_cycle", 32'(ld_collide), 0);
    drain(0);
    issue(ALU_PASSB, 3, 1);
    drain(0);

    // load during OPRD is not bypassed into operand b
    issue(ALU_PASSB, 3, 1);
    ld_valid = 1; ld_idx = 3; ld_data = 16'h1111;
    tick();
    ld_valid = 0;
    r_m[3] = 16'h1111;
    chk("no_bypass_alu_b", 32'(alu_b), 32'h0000BEEF);
    drain(0);
    issue(ALU_PASSB, 3, 1);
    drain(0);

    // reset during EXEC aborts the command
    load(1, 16'h1234);
    issue(ALU_ADD, 1, 0);
    tick();
    rst_n = 0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_acc", 32'(acc_q), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick();
    issue(ALU_PASSB, 1, 1);
    drain(0);

    // randomized commands and loads with random response backpressure
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) load(2'($urandom), 16'($urandom));
      issue(3'($urandom), 2'($urandom), 1'($urandom));
      drain(1);
    end
    for (int i = 0; i < NR; i++) begin
      issue(ALU_PASSB, 2'(i), 1);
      drain(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
